// File: rtl/pio_in_pkg.sv
// Shared constants for the PIO input-capture block: register map and edge-mode encodings.
package pio_in_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pio_in_bit_filter.sv
// One pin: multi-flop synchroniser followed by an optional stability (glitch) filter.
module pio_in_bit_filter
  import pio_in_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign o_level = w_sync;
    end else begin : g_filter
      localparam int unsigned CNT_W = cnt_width(FILTER_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

      logic [CNT_W-1:0] r_cnt;
      logic             r_level;

      // The level flips on the cycle the mismatch count would reach FILTER_CYCLES.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else if (w_sync == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_cnt   <= '0;
          r_level <= w_sync;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign o_level = r_level;
    end
  endgenerate

endmodule

// File: rtl/pio_in_capture.sv
// Avalon-MM PIO input port: synchronised/filtered pin levels, edge capture and masked level interrupt.
module pio_in_capture
  import pio_in_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 0,
  parameter int unsigned EDGE_MODE     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] w_level;
  logic [DATA_WIDTH-1:0] r_level_d;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_cap;
  logic                  w_mask_we;
  logic [REG_W-1:0]      w_rd_mux;
  logic [REG_W-1:0]      r_readdata;
  logic                  r_irq;

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      pio_in_bit_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_filt (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (in_port[gi]),
        .o_level(w_level[gi])
      );
    end

    if (EDGE_MODE == EDGE_FALL) begin : g_fall
      assign w_edge = ~w_level & r_level_d;
    end else if (EDGE_MODE == EDGE_ANY) begin : g_any
      assign w_edge = w_level ^ r_level_d;
    end else begin : g_rise
      assign w_edge = w_level & ~r_level_d;
    end

    // Sink for upper write-data bits that have no storage.
    if (DATA_WIDTH < REG_W) begin : g_wdata_hi
      logic w_unused_wdata;
      assign w_unused_wdata = ^writedata[REG_W-1:DATA_WIDTH];
    end
  endgenerate

  assign w_clr     = (write && (address == ADDR_EDGE)) ? writedata[DATA_WIDTH-1:0] : '0;
  assign w_mask_we = write && (address == ADDR_MASK);

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux = REG_W'(w_level);
      ADDR_RSVD: w_rd_mux = '0;
      ADDR_MASK: w_rd_mux = REG_W'(r_mask);
      ADDR_EDGE: w_rd_mux = REG_W'(r_cap);
      default:   w_rd_mux = '0;
    endcase
  end

  // New edges win over a simultaneous write-one-to-clear on the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level_d  <= '0;
      r_cap      <= '0;
      r_mask     <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_cap     <= (r_cap & ~w_clr) | w_edge;
      r_irq     <= |(r_cap & r_mask);
      if (w_mask_we) begin
        r_mask <= writedata[DATA_WIDTH-1:0];
      end
      if (read) begin
        r_readdata <= w_rd_mux;
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_pio_in_capture.sv
// Four differently configured capture ports on shared stimulus, each checked against a window-based model.
module tb_pio_in_capture;

  localparam int NI = 4;
  localparam int CFG_S [NI] = '{2, 3, 2, 4};
  localparam int CFG_F [NI] = '{0, 3, 0, 1};
  localparam int CFG_M [NI] = '{0, 0, 1, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [7:0]  pins = 8'h00;
  logic [31:0] rdata [NI];
  logic        irq_o [NI];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  pio_in_capture #(.DATA_WIDTH(8), .SYNC_STAGES(CFG_S[0]), .FILTER_CYCLES(CFG_F[0]), .EDGE_MODE(CFG_M[0])) u_dut0 (
    .clk(clk), .reset(rst), .address(address), .read(rd_en), .write(wr_en), .writedata(wdata),
    .readdata(rdata[0]), .in_port(pins), .irq(irq_o[0]));
  pio_in_capture #(.DATA_WIDTH(8), .SYNC_STAGES(CFG_S[1]), .FILTER_CYCLES(CFG_F[1]), .EDGE_MODE(CFG_M[1])) u_dut1 (
    .clk(clk), .reset(rst), .address(address), .read(rd_en), .write(wr_en), .writedata(wdata),
    .readdata(rdata[1]), .in_port(pins), .irq(irq_o[1]));
  pio_in_capture #(.DATA_WIDTH(8), .SYNC_STAGES(CFG_S[2]), .FILTER_CYCLES(CFG_F[2]), .EDGE_MODE(CFG_M[2])) u_dut2 (
    .clk(clk), .reset(rst), .address(address), .read(rd_en), .write(wr_en), .writedata(wdata),
    .readdata(rdata[2]), .in_port(pins), .irq(irq_o[2]));
  pio_in_capture #(.DATA_WIDTH(8), .SYNC_STAGES(CFG_S[3]), .FILTER_CYCLES(CFG_F[3]), .EDGE_MODE(CFG_M[3])) u_dut3 (
    .clk(clk), .reset(rst), .address(address), .read(rd_en), .write(wr_en), .writedata(wdata),
    .readdata(rdata[3]), .in_port(pins), .irq(irq_o[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: pinh[j] is the pin vector sampled j edges ago (zero while in reset).
  logic [7:0]  pinh [8];
  logic [7:0]  m_f [NI];
  logic [7:0]  m_fd [NI];
  logic [7:0]  m_cap [NI];
  logic [7:0]  m_mask [NI];
  logic        m_irq [NI];
  logic [31:0] m_rd [NI];
  logic [7:0]  t_edge, t_clr, t_ones, t_zeros, t_fnew;

  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 8; j++) pinh[j] = 8'h00;
      for (int i = 0; i < NI; i++) begin
        m_f[i] = 8'h00; m_fd[i] = 8'h00; m_cap[i] = 8'h00;
        m_mask[i] = 8'h00; m_irq[i] = 1'b0; m_rd[i] = 32'h0;
      end
    end else begin
      for (int j = 7; j > 0; j--) pinh[j] = pinh[j-1];
      pinh[0] = pins;
      for (int i = 0; i < NI; i++) begin
        case (CFG_M[i])
          1:       t_edge = ~m_f[i] & m_fd[i];
          2:       t_edge = m_f[i] ^ m_fd[i];
          default: t_edge = m_f[i] & ~m_fd[i];
        endcase
        if (rd_en) begin
          case (address)
            2'd0:    m_rd[i] = {24'h0, m_f[i]};
            2'd2:    m_rd[i] = {24'h0, m_mask[i]};
            2'd3:    m_rd[i] = {24'h0, m_cap[i]};
            default: m_rd[i] = 32'h0;
          endcase
        end
        t_clr = (wr_en && address == 2'd3) ? wdata[7:0] : 8'h00;
        m_irq[i] = |(m_cap[i] & m_mask[i]);
        m_cap[i] = (m_cap[i] & ~t_clr) | t_edge;
        if (wr_en && address == 2'd2) m_mask[i] = wdata[7:0];
        // Filtered level follows the synchronised pin once its last F samples all agree.
        if (CFG_F[i] == 0) begin
          t_fnew = pinh[CFG_S[i]-1];
        end else begin
          t_ones = 8'hFF; t_zeros = 8'hFF;
          for (int k = 0; k < CFG_F[i]; k++) begin
            t_ones  = t_ones & pinh[CFG_S[i]+k];
            t_zeros = t_zeros & ~pinh[CFG_S[i]+k];
          end
          t_fnew = (m_f[i] & ~(t_ones | t_zeros)) | t_ones;
        end
        m_fd[i] = m_f[i];
        m_f[i]  = t_fnew;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("rd%0d", i), rdata[i], m_rd[i]);
        check($sformatf("irq%0d", i), {31'h0, irq_o[i]}, {31'h0, m_irq[i]});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    cycles(3);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_rd%0d", i), rdata[i], 32'h0);
      check($sformatf("rst_irq%0d", i), {31'h0, irq_o[i]}, 32'h0);
    end
    rst = 1'b0;
    chk_en = 1'b1;
    cycles(2);

    // Basic rising capture and write-one-to-clear.
    pins = 8'h05;
    cycles(4);
    bus_read(2'd3);
    check("cap_05", rdata[0], 32'h05);
    bus_write(2'd3, 32'h01);
    bus_read(2'd3);
    check("cap_after_clr", rdata[0], 32'h04);

    // Masked interrupt timing.
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h04);
    pins = 8'h00;
    cycles(8);
    bus_write(2'd3, 32'hFF);
    cycles(2);
    check("irq_idle", {31'h0, irq_o[0]}, 32'h0);
    pins = 8'h04;
    cycles(3);
    check("irq_not_yet", {31'h0, irq_o[0]}, 32'h0);
    cycles(1);
    check("irq_set", {31'h0, irq_o[0]}, 32'h1);
    bus_write(2'd3, 32'h04);
    check("irq_hold", {31'h0, irq_o[0]}, 32'h1);
    cycles(1);
    check("irq_drop", {31'h0, irq_o[0]}, 32'h0);
    pins = 8'h05;
    cycles(6);
    check("irq_unmasked", {31'h0, irq_o[0]}, 32'h0);

    // Glitch filter: short pulse rejected, long pulse passes three cycles after sync.
    pins = 8'h00;
    cycles(12);
    bus_write(2'd3, 32'hFF);
    pins = 8'h01;
    cycles(2);
    pins = 8'h00;
    cycles(12);
    bus_read(2'd3);
    check("glitch_cap", rdata[1], 32'h0);
    bus_read(2'd0);
    check("glitch_data", rdata[1], 32'h0);
    address = 2'd0; rd_en = 1'b1;
    pins = 8'h01;
    cycles(5);
    pins = 8'h00;
    cycles(1);
    check("filt_before", rdata[1], 32'h0);
    cycles(1);
    check("filt_after", rdata[1], 32'h1);
    rd_en = 1'b0;
    cycles(12);

    // Falling and any-edge modes.
    bus_write(2'd3, 32'hFF);
    pins = 8'hFF;
    cycles(10);
    bus_read(2'd3);
    check("fall_on_rise", rdata[2], 32'h0);
    check("any_on_rise", rdata[3], 32'hFF);
    bus_write(2'd3, 32'hFF);
    pins = 8'h00;
    cycles(10);
    bus_read(2'd3);
    check("fall_on_fall", rdata[2], 32'hFF);
    check("any_on_fall", rdata[3], 32'hFF);

    // Edge arriving on the same cycle as its clear survives.
    bus_write(2'd3, 32'hFF);
    cycles(2);
    pins = 8'h01;
    cycles(2);
    bus_write(2'd3, 32'h01);
    bus_read(2'd3);
    check("edge_vs_clr", rdata[0], 32'h01);

    // Reset mid-count with irq high; nothing captured afterwards with pins low.
    bus_write(2'd2, 32'hFF);
    pins = 8'hFF;
    cycles(8);
    check("irq_pre_rst", {31'h0, irq_o[0]}, 32'h1);
    pins = 8'h00;
    cycles(4);
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("arst_rd%0d", i), rdata[i], 32'h0);
      check($sformatf("arst_irq%0d", i), {31'h0, irq_o[i]}, 32'h0);
    end
    cycles(2);
    rst = 1'b0;
    cycles(12);
    bus_read(2'd3);
    for (int i = 0; i < NI; i++) check($sformatf("post_rst_cap%0d", i), rdata[i], 32'h0);

    // Pins high across reset release register as rising edges.
    rst = 1'b1;
    pins = 8'hFF;
    cycles(2);
    rst = 1'b0;
    cycles(8);
    bus_read(2'd3);
    check("rel_high0", rdata[0], 32'hFF);
    check("rel_high1", rdata[1], 32'hFF);

    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        pins = 8'($urandom);
        cycles(2);
        rst = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) pins = 8'($urandom);
        else pins = pins ^ 8'(1 << $urandom_range(0, 7));
      end
      address = 2'($urandom_range(0, 3));
      rd_en   = ($urandom_range(0, 9) < 6);
      wr_en   = ($urandom_range(0, 9) < 2);
      wdata   = $urandom;
      @(negedge clk);
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
